fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Controller for the F stage. It owns the fetch PC, runs the request/ready handshake to instruction memory, and absorbs D-stage stalls in a one-entry skid buffer. It applies branch/jump redirects from D and presents one instruction per cycle to the F/D boundary. It replaces the free-running PC+stall scheme with a sequencer that tolerates wait-state memory.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset
- ADDR_W, 32, PC and instruction width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; low = in reset
- stall_d  in  1  D stage cannot accept this cycle
- redirect_valid  in  1  one-cycle pulse, redirect fetch
- redirect_pc  in  32  redirect target, sampled with redirect_valid
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address
- imem_ready  in  1  imem_rdata valid this cycle; completes request
- imem_rdata  in  32  fetched instruction
- instr_valid  out  1  output slot holds an instruction
- instr  out  32  instruction to D
- instr_pc  out  32  its PC
- instr_pc4  out  32  instr_pc + 4, modulo 2^32

## Operation
- accept = instr_valid & ~stall_d & ~redirect_valid
- Storage:
  - pc: next fetch address
  - tgt: pending redirect target
  - output slot: instr, instr_pc, instr_valid
  - skid: one entry plus valid bit
- Handshake: imem_req stays high until the cycle imem_ready is seen. imem_addr is stable while imem_req is high. imem_ready is permitted in the same cycle imem_req rises (zero wait states). Memory ignores imem_ready when imem_req is low.
- States:
  - S_REQ: imem_req=1, imem_addr=pc
  - S_WAITSLOT: imem_req=0, skid full
  - S_DROP: imem_req=1, imem_addr=pc (stale request), data will be discarded
- S_REQ, imem_ready, no redirect:
  - Data goes to the output slot if the slot is empty or accept is high; otherwise it goes to the skid.
  - pc <= pc+4.
  - Next state is S_WAITSLOT if the skid is full after this cycle; otherwise S_REQ.
- S_WAITSLOT, accept: skid moves to the output slot, skid clears, next state S_REQ.
- Output slot with no new data: on accept it refills from the skid if the skid is valid; otherwise instr_valid <= 0.
- redirect_valid (any state):
  - Clear the output slot and the skid.
  - Redirect beats accept.
  - If a request is outstanding and imem_ready is low (S_REQ or S_DROP): tgt <= redirect_pc, next state S_DROP.
  - Otherwise: pc <= redirect_pc, next state S_REQ, and any same-cycle imem_rdata is discarded.
- S_DROP, imem_ready: discard data, pc <= tgt, next state S_REQ. A repeated redirect in S_DROP overwrites tgt.
- No delay-slot logic lives here. D asserts redirect only after the delay-slot instruction has been accepted, so everything still held here is younger and is flushed.
- Arithmetic: pc+4 wraps modulo 2^32; no alignment checks.

## Timing
- Reset (async, while reset=0):
  - state=S_REQ, pc=RESET_PC, tgt=0, skid invalid
  - instr_valid=0, instr=0, instr_pc=0
  - imem_req forced 0
- First cycle after release: imem_req=1, imem_addr=RESET_PC.
- Latency: instr_valid rises the cycle after imem_ready.
- Throughput: 1 instruction/cycle with zero-wait memory and no stall.
- Redirect cost with zero-wait memory: next imem_addr=redirect_pc in the following cycle; instr_valid low for exactly one cycle.
- Reset asserted mid-transaction: outstanding request abandoned, no data retained, imem_req drops immediately (asynchronously).

## Structure
- Shared package fetch_pkg holds the state enum (S_REQ, S_WAITSLOT, S_DROP) and the default RESET_PC constant.
- Sub-module fetch_buf: output slot plus skid entry, with load, accept and flush controls.
- The sequencer FSM and pc/tgt registers live in fetch_sequencer.

## Test plan
- Release from reset, zero-wait memory, no stall:
  - imem_addr runs 0x3000, 0x3004, 0x3008…
  - instr_valid first high the cycle after the first imem_ready, with instr_pc=0x3000 and instr_pc4=0x3004.
- stall_d high 3 cycles while 0x3008 is in the output slot:
  - 0x300C lands in the skid; imem_req drops (S_WAITSLOT).
  - After release, D receives 0x3008 then 0x300C, and imem_addr=0x3010, with no loss or duplication.
- Zero-wait redirect to 0x3100 while 0x3010 is in flight:
  - The 0x3010 data is discarded.
  - Next imem_addr=0x3100; instr_valid low one cycle; next instr_pc=0x3100.
- 3-wait-state memory, redirect to 0x3200 while 0x3010 is outstanding:
  - imem_addr holds 0x3010 until imem_ready; that data is never output.
  - Next request is 0x3200.
- Redirect to 0x3300 in S_WAITSLOT with stall_d high:
  - Output slot and skid are both cleared.
  - imem_req=1, imem_addr=0x3300 the next cycle.
- reset pulled low during an outstanding wait-state request:
  - imem_req and instr_valid go low immediately.
  - After release, fetch restarts at 0x3000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the F-stage fetch sequencer: FSM state encoding
// and the default post-reset fetch address.
package fetch_pkg;

    // S_REQ      : request outstanding at pc, data is wanted
    // S_WAITSLOT : output slot and skid both full, no request issued
    // S_DROP     : stale request still outstanding, its data is thrown away
    typedef enum logic [1:0] {
        S_REQ      = 2'd0,
        S_WAITSLOT = 2'd1,
        S_DROP     = 2'd2
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/fetch_buf.sv
// Output slot toward D plus a one-entry skid. The skid absorbs the one
// instruction that returns from memory while D is stalled on the slot.
module fetch_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              accept,
    input  logic              flush,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              skid_valid
);

    logic [ADDR_W-1:0] skid_instr;
    logic [ADDR_W-1:0] skid_pc;
    logic              slot_free;

    // The slot can take new contents when it is empty or D takes it now.
    assign slot_free = ~instr_valid | accept;

    // Slot/skid update: flush wins, then the skid drains ahead of new data
    // so program order is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
        end else if (flush) begin
            instr_valid <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (slot_free) begin
            if (skid_valid) begin
                instr       <= skid_instr;
                instr_pc    <= skid_pc;
                instr_valid <= 1'b1;
                skid_valid  <= load;
                if (load) begin
                    skid_instr <= load_instr;
                    skid_pc    <= load_pc;
                end
            end else if (load) begin
                instr       <= load_instr;
                instr_pc    <= load_pc;
                instr_valid <= 1'b1;
            end else begin
                instr_valid <= 1'b0;
            end
        end else if (load) begin
            // Slot held by a stalled D: park the returning word.
            skid_instr <= load_instr;
            skid_pc    <= load_pc;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// F-stage fetch sequencer: owns the fetch pc, runs the req/ready handshake
// to instruction memory, applies redirects from D and feeds the F/D slot.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_d,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [ADDR_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] instr_pc4
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tgt;
    logic              accept;
    logic              load;
    logic              skid_fill;
    logic              skid_valid;

    // A redirect overrides D taking the current slot: that instruction is
    // younger than the branch's delay slot and must not be consumed.
    assign accept = instr_valid & ~stall_d & ~redirect_valid;

    // Only a completed, still-wanted request delivers data.
    assign load = (state == S_REQ) & imem_ready & ~redirect_valid;

    // Returning word lands in the skid when the slot stays occupied.
    assign skid_fill = load & instr_valid & ~accept;

    // Request is a decode of the state register; gating with reset makes it
    // drop the instant reset asserts, abandoning any outstanding access.
    assign imem_req  = reset & (state != S_WAITSLOT);
    assign imem_addr = pc;
    assign instr_pc4 = instr_pc + ADDR_W'(4);

    // Sequencer FSM with fetch pc and pending redirect target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_REQ;
            pc    <= RESET_PC;
            tgt   <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        if (imem_ready) begin
                            // Access completes now; its data is dropped.
                            pc <= redirect_pc;
                        end else begin
                            // Cannot retract an issued request: finish it
                            // at the old address, then jump.
                            tgt   <= redirect_pc;
                            state <= S_DROP;
                        end
                    end else if (imem_ready) begin
                        pc    <= pc + ADDR_W'(4);
                        state <= skid_fill ? S_WAITSLOT : S_REQ;
                    end
                end
                S_WAITSLOT: begin
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= S_REQ;
                    end else if (accept) begin
                        state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (redirect_valid) begin
                        if (imem_ready) begin
                            pc    <= redirect_pc;
                            state <= S_REQ;
                        end else begin
                            tgt <= redirect_pc;
                        end
                    end else if (imem_ready) begin
                        pc    <= tgt;
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    fetch_buf #(
        .ADDR_W(ADDR_W)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_instr (imem_rdata),
        .load_pc    (pc),
        .accept     (accept),
        .flush      (redirect_valid),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .skid_valid (skid_valid)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: wait-state memory model, scoreboard of held
// instructions, a per-cycle vector table and hand-written corner sequences.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_d = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;

    int checks = 0;
    int errors = 0;
    int waits = 0;
    int wcnt = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .ADDR_W  (32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_d       (stall_d),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_pc4     (instr_pc4)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: ready after 'waits' cycles of an outstanding request.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            imem_ready = imem_req && (wcnt >= waits);
            imem_rdata = imem_req ? mem_word(imem_addr) : 32'h0;
        end
    end

    // Scoreboard: q holds the instructions the DUT should be holding, in order.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;
    ent_t        q[$];
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_tgt = '0;
    bit          m_drop = 1'b0;

    initial begin
        bit req_m, acc, hs;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("sb_rst_req", {31'b0, imem_req}, 32'd0);
                chk("sb_rst_valid", {31'b0, instr_valid}, 32'd0);
                q.delete();
                m_pc   = RST_PC;
                m_drop = 1'b0;
                wcnt   = 0;
            end else begin
                req_m = (q.size() < 2);
                chk("sb_req", {31'b0, imem_req}, {31'b0, req_m});
                if (req_m) chk("sb_addr", imem_addr, m_pc);
                chk("sb_valid", {31'b0, instr_valid}, {31'b0, (q.size() > 0)});
                if (q.size() > 0) begin
                    chk("sb_pc", instr_pc, q[0].pc);
                    chk("sb_instr", instr, q[0].ins);
                    chk("sb_pc4", instr_pc4, q[0].pc + 32'd4);
                end
                acc = (q.size() > 0) && !stall_d && !redirect_valid;
                hs  = req_m && imem_ready;
                if (redirect_valid) begin
                    q.delete();
                    if (req_m && !imem_ready) begin
                        m_tgt  = redirect_pc;
                        m_drop = 1'b1;
                    end else begin
                        m_pc   = redirect_pc;
                        m_drop = 1'b0;
                    end
                end else begin
                    if (acc) void'(q.pop_front());
                    if (hs) begin
                        if (m_drop) begin
                            m_drop = 1'b0;
                            m_pc   = m_tgt;
                        end else begin
                            q.push_back('{m_pc, mem_word(m_pc)});
                            m_pc = m_pc + 32'd4;
                        end
                    end
                end
                if (hs) wcnt = 0;
                else if (req_m) wcnt++;
            end
        end
    end

    typedef struct {
        bit          stall;
        bit          rv;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_v;
        logic [31:0] e_ipc;
    } vec_t;

    function automatic vec_t mk(bit s, bit r, logic [31:0] rp, bit eq, logic [31:0] ea,
                                bit ev, logic [31:0] ep);
        vec_t v;
        v.stall = s; v.rv = r; v.rpc = rp;
        v.e_req = eq; v.e_addr = ea; v.e_v = ev; v.e_ipc = ep;
        return v;
    endfunction

    task automatic drive(input bit s, input bit r, input logic [31:0] rp);
        @(posedge clk);
        #1;
        stall_d        = s;
        redirect_valid = r;
        redirect_pc    = rp;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (instr_valid) found = 1'b1;
        end
        if (found) chk(name, instr_pc, exp_pc);
        else chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    vec_t tbl[12];

    initial begin
        bit found;
        // Release, stream, stall 3 cycles on 0x3008, then redirect to 0x3100
        // while 0x3014 is being fetched (0x3010 sits unaccepted in the slot).
        tbl[0]  = mk(1'b0, 1'b0, 32'h0,    1'b1, 32'h3000, 1'b0, 32'h0);
        tbl[1]  = mk(1'b0, 1'b0, 32'h0,    1'b1, 32'h3004, 1'b1, 32'h3000);
        tbl[2]  = mk(1'b0, 1'b0, 32'h0,    1'b1, 32'h3008, 1'b1, 32'h3004);
        tbl[3]  = mk(1'b1, 1'b0, 32'h0,    1'b1, 32'h300C, 1'b1, 32'h3008);
        tbl[4]  = mk(1'b1, 1'b0, 32'h0,    1'b0, 32'h3010, 1'b1, 32'h3008);
        tbl[5]  = mk(1'b1, 1'b0, 32'h0,    1'b0, 32'h3010, 1'b1, 32'h3008);
        tbl[6]  = mk(1'b0, 1'b0, 32'h0,    1'b0, 32'h3010, 1'b1, 32'h3008);
        tbl[7]  = mk(1'b0, 1'b0, 32'h0,    1'b1, 32'h3010, 1'b1, 32'h300C);
        tbl[8]  = mk(1'b0, 1'b1, 32'h3100, 1'b1, 32'h3014, 1'b1, 32'h3010);
        tbl[9]  = mk(1'b0, 1'b0, 32'h0,    1'b1, 32'h3100, 1'b0, 32'h0);
        tbl[10] = mk(1'b0, 1'b0, 32'h0,    1'b1, 32'h3104, 1'b1, 32'h3100);
        tbl[11] = mk(1'b0, 1'b0, 32'h0,    1'b1, 32'h3108, 1'b1, 32'h3104);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req", {31'b0, imem_req}, 32'd0);
        chk("reset_valid", {31'b0, instr_valid}, 32'd0);
        chk("reset_instr_pc", instr_pc, 32'd0);
        chk("reset_instr", instr, 32'd0);

        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) reset = 1'b1;
            stall_d        = tbl[i].stall;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_v});
            if (tbl[i].e_v) begin
                chk($sformatf("vec%0d_pc", i), instr_pc, tbl[i].e_ipc);
                chk($sformatf("vec%0d_pc4", i), instr_pc4, tbl[i].e_ipc + 32'd4);
                chk($sformatf("vec%0d_instr", i), instr, mem_word(tbl[i].e_ipc));
            end
        end

        // Wait-state redirect: jump to 0x3010, then redirect to 0x3200 while
        // the 3-wait 0x3010 access is outstanding.
        drive(1'b0, 1'b1, 32'h3010);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        waits = 3;
        @(negedge clk);
        chk("ws_addr0", imem_addr, 32'h3010);
        chk("ws_req0", {31'b0, imem_req}, 32'd1);
        drive(1'b0, 1'b1, 32'h3200);
        @(negedge clk);
        chk("ws_addr1", imem_addr, 32'h3010);
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 32'h0);
            @(negedge clk);
            chk("ws_addr_hold", imem_addr, 32'h3010);
            chk("ws_valid_low", {31'b0, instr_valid}, 32'd0);
        end
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("ws_next_addr", imem_addr, 32'h3200);
        chk("ws_next_valid", {31'b0, instr_valid}, 32'd0);
        wait_valid("ws_first_pc", 32'h3200);

        // Redirect while in S_WAITSLOT with D stalled.
        @(posedge clk);
        #1;
        waits = 0;
        stall_d = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk);
            if (!imem_req) found = 1'b1;
        end
        chk("ws_full_reached", {31'b0, found}, 32'd1);
        drive(1'b1, 1'b1, 32'h3300);
        drive(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("slot_redir_req", {31'b0, imem_req}, 32'd1);
        chk("slot_redir_addr", imem_addr, 32'h3300);
        chk("slot_redir_valid", {31'b0, instr_valid}, 32'd0);
        drive(1'b0, 1'b0, 32'h0);
        wait_valid("slot_redir_pc", 32'h3300);

        // Reset pulled mid-cycle during an outstanding wait-state request.
        @(posedge clk);
        #1;
        stall_d = 1'b1;
        waits = 3;
        repeat (2) @(negedge clk);
        chk("mid_req_pre", {31'b0, imem_req}, 32'd1);
        chk("mid_valid_pre", {31'b0, instr_valid}, 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_req_drop", {31'b0, imem_req}, 32'd0);
        chk("mid_valid_drop", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        waits = 0;
        stall_d = 1'b0;
        @(negedge clk);
        chk("restart_req", {31'b0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, RST_PC);
        wait_valid("restart_pc", RST_PC);

        // Random mix of stalls, redirects and wait states, scoreboard-checked.
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            stall_d        = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 32'h4000 + ($urandom_range(0, 255) << 2);
            waits          = $urandom_range(0, 2);
        end
        @(posedge clk);
        #1;
        stall_d = 1'b0;
        redirect_valid = 1'b0;
        waits = 0;
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
